// File: rtl/instruction_mem_mux.sv
// Second read-address select for the register file: picks addrRy or addrRz under Reg2Loc
// and registers the result so the read address is stable for a whole cycle.
module instruction_mem_mux #(
  parameter int ADDR_W = 2
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] addrRy,
  input  logic [ADDR_W-1:0] addrRz,
  input  logic              Reg2Loc,
  output logic [ADDR_W-1:0] out
);

  logic [ADDR_W-1:0] out_d;
  logic [ADDR_W-1:0] out_q;

  // NOTE: out_d gets a value on every path through the block, so no latch is inferred.
  always_comb begin
    out_d = addrRy;
    if (Reg2Loc) begin
      out_d = addrRz;
    end
  end

  // NOTE: Non-blocking assignment keeps the register update race-free against other clocked logic.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_q <= '0;
    end else begin
      out_q <= out_d;
    end
  end

  assign out = out_q;

endmodule

// File: tb/tb_instruction_mem_mux.sv
// Directed bench for instruction_mem_mux: a scoreboard queue holds the expected register
// address for each sampled edge, and each entry is compared with an immediate assertion.
module tb_instruction_mem_mux;

  localparam int ADDR_W = 2;

  logic              clock;
  logic              reset_n;
  logic [ADDR_W-1:0] addrRy;
  logic [ADDR_W-1:0] addrRz;
  logic              Reg2Loc;
  logic [ADDR_W-1:0] out_w;

  int total;
  int bad;

  logic [ADDR_W-1:0] exp_q[$];
  logic [ADDR_W-1:0] cur_model;

  instruction_mem_mux #(.ADDR_W(ADDR_W)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .addrRy  (addrRy),
    .addrRz  (addrRz),
    .Reg2Loc (Reg2Loc),
    .out     (out_w)
  );

  initial begin
    clock = 1'b0;
    forever #50 clock = ~clock;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check_val(input string tag, input logic [ADDR_W-1:0] expv);
    total++;
    assert (out_w === expv) else begin
      bad++;
      $error("FAIL %s: out=%0d expected=%0d", tag, out_w, expv);
    end
  endtask

  // Inputs change at the falling edge, well away from the sampling edge.
  task automatic drive(input logic [ADDR_W-1:0] ry, input logic [ADDR_W-1:0] rz,
                       input logic sel);
    @(negedge clock);
    addrRy  = ry;
    addrRz  = rz;
    Reg2Loc = sel;
    exp_q.push_back(sel ? rz : ry);
  endtask

  task automatic check_next(input string tag);
    logic [ADDR_W-1:0] expv;
    @(posedge clock);
    #10;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s: scoreboard empty, out=%0d expected=none", tag, out_w);
    end else begin
      expv      = exp_q.pop_front();
      cur_model = expv;
      check_val(tag, expv);
    end
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    cur_model = '0;

    // 1: reset held with clock running, then release
    reset_n = 1'b0;
    addrRy  = 2'd2;
    addrRz  = 2'd3;
    Reg2Loc = 1'b1;
    #1;
    check_val("rst_initial", 2'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clock);
      #10;
      check_val("rst_hold", 2'd0);
    end
    @(negedge clock);
    reset_n = 1'b1;
    exp_q.push_back(2'd3);
    check_next("rst_release");

    // 2: small fields
    drive(2'd0, 2'd1, 1'b0);
    check_next("sel0_ry0");
    drive(2'd0, 2'd1, 1'b1);
    check_next("sel1_rz1");

    // 3: large fields
    drive(2'd2, 2'd3, 1'b0);
    check_next("sel0_ry2");
    drive(2'd2, 2'd3, 1'b1);
    check_next("sel1_rz3");

    // 4: equal fields, Reg2Loc toggling
    for (int i = 0; i < 4; i++) begin
      drive(2'd0, 2'd0, i[0]);
      check_next("equal_fields");
    end

    // 5: mid-cycle change must not reach out before the next rising edge
    drive(2'd1, 2'd2, 1'b1);
    #40;
    check_val("no_early_change", cur_model);
    check_next("after_edge");
    drive(2'd3, 2'd1, 1'b0);
    #40;
    check_val("no_early_change2", cur_model);
    check_next("after_edge2");

    // 6: asynchronous reset between edges discards the pending sample
    drive(2'd2, 2'd3, 1'b1);
    check_next("pre_async_rst");
    drive(2'd0, 2'd1, 1'b0);
    #20;
    reset_n = 1'b0;
    #5;
    exp_q.delete();
    cur_model = '0;
    check_val("async_rst_now", 2'd0);
    @(posedge clock);
    #10;
    check_val("async_rst_edge", 2'd0);
    @(negedge clock);
    reset_n = 1'b1;
    addrRy  = 2'd2;
    addrRz  = 2'd1;
    Reg2Loc = 1'b0;
    exp_q.push_back(2'd2);
    check_next("post_async_rst");
    drive(2'd2, 2'd1, 1'b1);
    check_next("post_async_rst_sel1");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
